// File: rtl/dbus_pkg.sv
// Shared types and helpers for the DBUS interconnect: FSM state encoding,
// select-index width helper and the default response timeout.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT = 16;

    // Width of the slave index field taken from the top of the address.
    function automatic int sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/dbus_decoder.sv
// Combinational address decoder: top address bits select one of N_SLAVES slaves;
// an index beyond the populated slaves yields valid=0 and an all-zero select.
module dbus_decoder
    import dbus_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [N_SLAVES-1:0] sel,
    output logic                valid
);

    localparam int SEL_W = sel_width(N_SLAVES);

    logic [SEL_W-1:0] idx;
    logic             unused_low;

    assign idx        = addr[ADDR_W-1 -: SEL_W];
    assign unused_low = ^addr[ADDR_W-SEL_W-1:0];

    always_comb begin
        valid = (int'(idx) < N_SLAVES);
        sel   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (int'(idx) == k) sel[k] = 1'b1;
        end
    end

endmodule

// File: rtl/dbus_interconnect.sv
// DBUS interconnect: one master, N_SLAVES decoded slaves, wait states, timeout and
// decode-error responses. Define DBUS_ERR_IRQ_EN for a sticky error IRQ with address capture.
module dbus_interconnect
    import dbus_pkg::*;
#(
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    localparam int BE_W     = DATA_W / 8,
    localparam int CNT_W    = $clog2(TIMEOUT) + 1
) (
    input  logic                       i_Clk,
    input  logic                       i_Rstn,
    input  logic                       i_Req,
    input  logic                       i_We,
    input  logic [ADDR_W-1:0]          i_Addr,
    input  logic [DATA_W-1:0]          i_WData,
    input  logic [BE_W-1:0]            i_BE,
    output logic [DATA_W-1:0]          o_RData,
    output logic                       o_Ready,
    output logic                       o_Err,
    output logic                       o_Busy,
    output logic [N_SLAVES-1:0]        o_s_Sel,
    output logic                       o_s_We,
    output logic [ADDR_W-1:0]          o_s_Addr,
    output logic [DATA_W-1:0]          o_s_WData,
    output logic [BE_W-1:0]            o_s_BE,
    input  logic [N_SLAVES*DATA_W-1:0] i_s_RData,
    input  logic [N_SLAVES-1:0]        i_s_Ready,
`ifdef DBUS_ERR_IRQ_EN
    input  logic                       i_IrqClr,
    output logic                       o_ErrIrq,
    output logic [ADDR_W-1:0]          o_ErrAddr,
`endif
    output logic [1:0]                 o_DbgState
);

    // Handshake: the master raises i_Req with stable fields and holds it until the
    // single-cycle o_Ready pulse, which carries o_RData/o_Err; the selected slave sees
    // o_s_Sel held until it pulses i_s_Ready or the timeout expires.
    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [N_SLAVES-1:0] sel_r, dec_sel;
    logic                dec_valid, err_r, hit, timeout;
    logic [DATA_W-1:0]   slave_rdata;

    dbus_decoder #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W)
    ) u_decoder (
        .addr  (i_Addr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    always_comb begin
        slave_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_r[k]) slave_rdata = slave_rdata | i_s_RData[k*DATA_W +: DATA_W];
        end
    end

    // Only the selected slave's ready counts; a ready on the last cycle beats the timeout.
    assign hit     = |(i_s_Ready & sel_r);
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_Ready   = 1'b0;
        o_Err     = 1'b0;
        o_s_Sel   = '0;
        o_Busy    = (state != IDLE);
        case (state)
            IDLE: if (i_Req) state_nxt = dec_valid ? WAIT : RESP;
            WAIT: begin
                o_s_Sel = sel_r;
                if (hit || timeout) state_nxt = RESP;
            end
            RESP: begin
                o_Ready   = 1'b1;
                o_Err     = err_r;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            cnt       <= '0;
            sel_r     <= '0;
            err_r     <= 1'b0;
            o_RData   <= '0;
            o_s_We    <= 1'b0;
            o_s_Addr  <= '0;
            o_s_WData <= '0;
            o_s_BE    <= '0;
        end else begin
            case (state)
                IDLE: if (i_Req) begin
                    o_s_We    <= i_We;
                    o_s_Addr  <= i_Addr;
                    o_s_WData <= i_WData;
                    o_s_BE    <= i_BE;
                    sel_r     <= dec_sel;
                    err_r     <= !dec_valid;
                    if (!dec_valid && !i_We) o_RData <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (hit) begin
                        err_r <= 1'b0;
                        if (!o_s_We) o_RData <= slave_rdata;
                    end else if (timeout) begin
                        err_r <= 1'b1;
                        if (!o_s_We) o_RData <= '0;
                    end
                end
                RESP: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

`ifdef DBUS_ERR_IRQ_EN
    // Address is captured only while the flag is clear, so it names the first error.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            o_ErrIrq  <= 1'b0;
            o_ErrAddr <= '0;
        end else if (state == RESP && err_r) begin
            o_ErrIrq <= 1'b1;
            if (!o_ErrIrq) o_ErrAddr <= o_s_Addr;
        end else if (i_IrqClr) begin
            o_ErrIrq <= 1'b0;
        end
    end
`endif

    assign o_DbgState = state;

endmodule

// File: tb/tb_dbus_interconnect.sv
// Self-checking bench for dbus_interconnect (N_SLAVES=3, TIMEOUT=16): directed cases
// plus randomized transactions checked every cycle against a per-transaction timeline model.
module tb_dbus_interconnect;
    import dbus_pkg::*;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rstn;
    logic req, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] rdata;
    logic ready, err, busy;
    logic [NS-1:0] s_sel;
    logic s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [BW-1:0] s_be;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0] s_ready;
    logic [1:0] dbg_state;
`ifdef DBUS_ERR_IRQ_EN
    logic irq_clr, err_irq;
    logic [AW-1:0] err_addr;
`endif

    typedef struct packed {
        logic          busy;
        logic          ready;
        logic          err;
        logic [NS-1:0] sel;
        logic [DW-1:0] rdata;
        logic          chk_s;
        logic          s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic [BW-1:0] s_be;
    } exp_t;

    exp_t exp_q[$];
    logic [DW-1:0] model_rdata;
    bit chk_en;
    int total, bad;

    dbus_interconnect #(
        .N_SLAVES (NS),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .i_Clk      (clk),
        .i_Rstn     (rstn),
        .i_Req      (req),
        .i_We       (we),
        .i_Addr     (addr),
        .i_WData    (wdata),
        .i_BE       (be),
        .o_RData    (rdata),
        .o_Ready    (ready),
        .o_Err      (err),
        .o_Busy     (busy),
        .o_s_Sel    (s_sel),
        .o_s_We     (s_we),
        .o_s_Addr   (s_addr),
        .o_s_WData  (s_wdata),
        .o_s_BE     (s_be),
        .i_s_RData  (s_rdata),
        .i_s_Ready  (s_ready),
`ifdef DBUS_ERR_IRQ_EN
        .i_IrqClr   (irq_clr),
        .o_ErrIrq   (err_irq),
        .o_ErrAddr  (err_addr),
`endif
        .o_DbgState (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one expected entry per cycle while a transaction runs, idle otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e = '0;
                    e.rdata = model_rdata;
                end
                check("busy",  32'(busy),  32'(e.busy));
                check("ready", 32'(ready), 32'(e.ready));
                check("err",   32'(err),   32'(e.err));
                check("sel",   32'(s_sel), 32'(e.sel));
                check("rdata", rdata,      e.rdata);
                if (e.chk_s) begin
                    check("s_we",    32'(s_we), 32'(e.s_we));
                    check("s_addr",  s_addr,    e.s_addr);
                    check("s_wdata", s_wdata,   e.s_wdata);
                    check("s_be",    32'(s_be), 32'(e.s_be));
                end
            end
        end
    end

    // Driver: one master transaction with the slave side scripted to answer after
    // wait_n wait states (wait_n >= TO means the slave never answers in time).
    task automatic do_txn(input logic t_we, input logic [AW-1:0] t_addr,
                          input logic [DW-1:0] t_wdata, input logic [BW-1:0] t_be,
                          input int wait_n, input logic [DW-1:0] rd_val,
                          output int lat, output int sel_cnt);
        int idx, n;
        bit ok, done_ok;
        exp_t e;
        logic [DW-1:0] new_rd;
        idx     = int'(t_addr[AW-1 -: 2]);
        ok      = (idx < NS);
        done_ok = ok && (wait_n < TO);
        n       = !ok ? 0 : (done_ok ? wait_n + 1 : TO);
        new_rd  = t_we ? model_rdata : (done_ok ? rd_val : '0);
        lat     = -1;
        sel_cnt = 0;
        for (int c = 0; c <= n + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                e = '0;
                e.rdata = model_rdata;
                exp_q.push_back(e);
                e.busy    = 1'b1;
                e.chk_s   = 1'b1;
                e.s_we    = t_we;
                e.s_addr  = t_addr;
                e.s_wdata = t_wdata;
                e.s_be    = t_be;
                e.sel     = ok ? NS'(1 << idx) : '0;
                for (int w = 1; w <= n; w++) exp_q.push_back(e);
                e.sel   = '0;
                e.ready = 1'b1;
                e.err   = !done_ok;
                e.rdata = new_rd;
                exp_q.push_back(e);
                model_rdata = new_rd;
                req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
            end else begin
                we = 1'($urandom()); addr = $urandom(); wdata = $urandom(); be = BW'($urandom());
            end
            for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = $urandom();
            s_ready = NS'($urandom());
            if (ok) begin
                s_ready[idx] = (c >= 1 && c - 1 == wait_n);
                if (c >= 1 && c - 1 == wait_n) s_rdata[idx*DW +: DW] = rd_val;
            end
            @(negedge clk);
            if (ready && lat < 0) lat = c;
            if (s_sel != '0) sel_cnt++;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            s_ready = NS'($urandom());
        end
    endtask

    initial begin
        int lat, sc, w;
        logic [AW-1:0] a;
        total = 0; bad = 0; chk_en = 0; model_rdata = '0;
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        s_rdata = '0; s_ready = '0;
`ifdef DBUS_ERR_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_err",   32'(err),   0);
        check("rst_busy",  32'(busy),  0);
        check("rst_sel",   32'(s_sel), 0);
        check("rst_rdata", rdata,      0);
        check("rst_saddr", s_addr,     0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk_en = 1;

        // Zero-wait read from slave 1
        do_txn(1'b0, 32'h4000_0010, 32'h0, 4'hF, 0, 32'hDEADBEEF, lat, sc);
        check("zw_lat", lat, 2);
        check("zw_rdata", rdata, 32'hDEADBEEF);
        check("zw_err", 32'(err), 0);
        check("zw_model", model_rdata, 32'hDEADBEEF);
        idle(1);

        // Write with three wait states: read data must not move
        do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0011, 3, 32'h5555_AAAA, lat, sc);
        check("wr_lat", lat, 5);
        check("wr_selcnt", sc, 4);
        check("wr_rdata", rdata, 32'hDEADBEEF);

        // Decode error read (index 3 with three slaves)
        do_txn(1'b0, 32'hC000_0000, 32'h0, 4'hF, 0, 32'h1111_2222, lat, sc);
        check("de_lat", lat, 1);
        check("de_selcnt", sc, 0);
        check("de_err", 32'(err), 1);
        check("de_rdata", rdata, 0);

        // Timeout on slave 2, then ready exactly on the last wait cycle
        do_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 99, 32'h7777_7777, lat, sc);
        check("to_lat", lat, 17);
        check("to_selcnt", sc, 16);
        check("to_err", 32'(err), 1);
        do_txn(1'b0, 32'h8000_0040, 32'h0, 4'hF, TO - 1, 32'hA5A5_0F0F, lat, sc);
        check("tr_lat", lat, 17);
        check("tr_err", 32'(err), 0);
        check("tr_rdata", rdata, 32'hA5A5_0F0F);

        // Erroring write leaves read data alone
        do_txn(1'b1, 32'hF000_0000, 32'hCAFE_0000, 4'hF, 0, 32'h0, lat, sc);
        check("dew_err", 32'(err), 1);
        check("dew_rdata", rdata, 32'hA5A5_0F0F);
        idle(2);

        // Reset during the second wait cycle
        @(posedge clk);
        #1;
        chk_en = 0;
        req = 1'b1; we = 1'b0; addr = 32'h8000_0000; s_ready = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_sel_pre", 32'(s_sel), 32'b100);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_sel", 32'(s_sel), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_ready", 32'(ready), 0);
        check("mid_rdata", rdata, 0);
        req = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_rdata = '0;
        chk_en = 1;
        idle(2);
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'h0BAD_F00D, lat, sc);
        check("post_lat", lat, 2);
        check("post_rdata", rdata, 32'h0BAD_F00D);
        idle(1);

`ifdef DBUS_ERR_IRQ_EN
        check("irq_rst", 32'(err_irq), 0);
        do_txn(1'b0, 32'hC000_0000, 32'h0, 4'hF, 0, 32'h0, lat, sc);
        do_txn(1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 32'h0, lat, sc);
        idle(1);
        @(negedge clk);
        check("irq_set", 32'(err_irq), 1);
        check("irq_addr", err_addr, 32'hC000_0000);
        @(posedge clk);
        #1;
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        @(negedge clk);
        check("irq_clr", 32'(err_irq), 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            a = $urandom();
            if ($urandom_range(0, 9) < 2) w = $urandom_range(TO - 2, TO + 2);
            else                          w = $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), a, $urandom(), BW'($urandom()), w, $urandom(), lat, sc);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        @(negedge clk);
        check("end_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
